// File: rtl/rotor_step_ctrl.sv
// Rotor stepping sequencer: loads rotor positions via a config port, then steps them per key.
// Build option ROTOR_DOUBLE_STEP_EN selects notch double-stepping; undefined gives a pure odometer.
module rotor_step_ctrl #(
  parameter int ALPHA   = 26,
  parameter int NOTCH_R = 21,
  parameter int NOTCH_M = 4,
  parameter int NOTCH_L = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_sel,
  input  logic [4:0] cfg_pos,
  input  logic       cfg_done,
  input  logic       cfg_start,
  output logic       cfg_err,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       step_valid,
  output logic [4:0] pos_r,
  output logic [4:0] pos_m,
  output logic [4:0] pos_l,
  output logic       in_cfg
);

  localparam logic [5:0] ALPHA6  = 6'(ALPHA);
  localparam logic [4:0] NOTCH_R5 = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M5 = 5'(NOTCH_M);

  typedef enum logic [1:0] {S_CONFIG, S_IDLE, S_HOLD} state_t;

  state_t     state_q;
  logic [4:0] pos_r_q, pos_m_q, pos_l_q;
  logic [4:0] pos_r_d, pos_m_d, pos_l_d;
  logic       key_ready_q, step_valid_q, cfg_err_q, in_cfg_q;
  logic       step_m, step_l, cfg_ok;

  // The left notch only exists for symmetry with the other rotors.
  logic unused_notch_l;
  assign unused_notch_l = ^5'(NOTCH_L);

  // Widen to 6 bits so the compare against ALPHA sees the carry; avoids a modulo.
  function automatic logic [4:0] wrap_inc(input logic [4:0] p, input logic en);
    logic [5:0] s;
    s = {1'b0, p} + {5'd0, en};
    if (s >= ALPHA6) s = 6'd0;
    return s[4:0];
  endfunction

  always_comb begin
`ifdef ROTOR_DOUBLE_STEP_EN
    step_m = (pos_r_q == NOTCH_R5) | (pos_m_q == NOTCH_M5);
    step_l = (pos_m_q == NOTCH_M5);
`else
    step_m = (pos_r_q == NOTCH_R5);
    step_l = (pos_m_q == NOTCH_M5) & step_m;
`endif
    pos_r_d = wrap_inc(pos_r_q, 1'b1);
    pos_m_d = wrap_inc(pos_m_q, step_m);
    pos_l_d = wrap_inc(pos_l_q, step_l);
    cfg_ok  = (cfg_sel != 2'd3) && ({1'b0, cfg_pos} < ALPHA6);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CONFIG;
      pos_r_q      <= '0;
      pos_m_q      <= '0;
      pos_l_q      <= '0;
      key_ready_q  <= 1'b0;
      step_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      in_cfg_q     <= 1'b1;
    end else begin
      step_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      case (state_q)
        S_CONFIG: begin
          if (cfg_valid) begin
            if (cfg_ok) begin
              case (cfg_sel)
                2'd0:    pos_r_q <= cfg_pos;
                2'd1:    pos_m_q <= cfg_pos;
                2'd2:    pos_l_q <= cfg_pos;
                default: ;
              endcase
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (cfg_done) begin
            state_q     <= S_IDLE;
            in_cfg_q    <= 1'b0;
            key_ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          // A key beats a simultaneous cfg_start; the request is not remembered.
          if (key_valid) begin
            pos_r_q      <= pos_r_d;
            pos_m_q      <= pos_m_d;
            pos_l_q      <= pos_l_d;
            state_q      <= S_HOLD;
            key_ready_q  <= 1'b0;
            step_valid_q <= 1'b1;
          end else if (cfg_start) begin
            state_q     <= S_CONFIG;
            in_cfg_q    <= 1'b1;
            key_ready_q <= 1'b0;
          end
        end
        S_HOLD: begin
          state_q     <= S_IDLE;
          key_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_CONFIG;
          in_cfg_q    <= 1'b1;
          key_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign pos_r      = pos_r_q;
  assign pos_m      = pos_m_q;
  assign pos_l      = pos_l_q;
  assign key_ready  = key_ready_q;
  assign step_valid = step_valid_q;
  assign cfg_err    = cfg_err_q;
  assign in_cfg     = in_cfg_q;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Directed bench for rotor_step_ctrl; expectations follow the ROTOR_DOUBLE_STEP_EN setting.
module tb_rotor_step_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_done, cfg_start, key_valid;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_pos;
  logic       cfg_err, key_ready, step_valid, in_cfg;
  logic [4:0] pos_r, pos_m, pos_l;

  int n_tests = 0;
  int n_fail  = 0;

  rotor_step_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_pos(cfg_pos),
    .cfg_done(cfg_done), .cfg_start(cfg_start), .cfg_err(cfg_err),
    .key_valid(key_valid), .key_ready(key_ready), .step_valid(step_valid),
    .pos_r(pos_r), .pos_m(pos_m), .pos_l(pos_l), .in_cfg(in_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int l, input int m, input int r);
    chk({tag, ".l"}, int'(pos_l), l);
    chk({tag, ".m"}, int'(pos_m), m);
    chk({tag, ".r"}, int'(pos_r), r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int sel, input int pos);
    cfg_valid = 1'b1;
    cfg_sel   = 2'(sel);
    cfg_pos   = 5'(pos);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic finish_cfg();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
  endtask

  task automatic enter_cfg();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic press(input string tag, input int l, input int m, input int r);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk({tag, ".sv"}, int'(step_valid), 1);
    chk({tag, ".kr"}, int'(key_ready), 0);
    chk_pos(tag, l, m, r);
    tick();
    chk({tag, ".sv_off"}, int'(step_valid), 0);
  endtask

  initial begin
    int acc;
    rst = 1'b1; cfg_valid = 0; cfg_sel = 0; cfg_pos = 0;
    cfg_done = 0; cfg_start = 0; key_valid = 0;
    tick();
    tick();
    rst = 1'b0;
    chk_pos("rst", 0, 0, 0);
    chk("rst.in_cfg", int'(in_cfg), 1);
    chk("rst.kr", int'(key_ready), 0);
    chk("rst.sv", int'(step_valid), 0);
    chk("rst.err", int'(cfg_err), 0);

    // Basic load and three steps through the right notch.
    cfg_wr(0, 20); cfg_wr(1, 3); cfg_wr(2, 0);
    chk_pos("load1", 0, 3, 20);
    finish_cfg();
    chk("idle.kr", int'(key_ready), 1);
    chk("idle.in_cfg", int'(in_cfg), 0);
    press("k1", 0, 3, 21);
    press("k2", 0, 4, 22);
`ifdef ROTOR_DOUBLE_STEP_EN
    press("k3", 1, 5, 23);
`else
    press("k3", 0, 4, 23);
`endif

    // Wrap of right and left at the top of the alphabet.
    enter_cfg();
    chk("cfg.in_cfg", int'(in_cfg), 1);
    chk("cfg.kr", int'(key_ready), 0);
    cfg_wr(0, 25); cfg_wr(1, 0); cfg_wr(2, 25);
    finish_cfg();
    press("wrapr", 25, 0, 0);
    enter_cfg();
    cfg_wr(0, 21); cfg_wr(1, 25);
    finish_cfg();
    press("wrapm", 25, 0, 22);

    // Continuous key_valid: one accept every other cycle.
    acc = 0;
    key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("burst.kr%0d", i), int'(key_ready), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("burst.sv%0d", i), int'(step_valid), (i % 2 == 1) ? 1 : 0);
      if (key_ready) acc++;
      tick();
    end
    key_valid = 1'b0;
    chk("burst.acc", acc, 5);
    chk_pos("burst", 25, 0, 1);

    // Rejected writes pulse cfg_err back to back and leave positions alone.
    enter_cfg();
    cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_pos = 5'd7;
    tick();
    chk("err1", int'(cfg_err), 1);
    cfg_sel = 2'd1; cfg_pos = 5'd26;
    tick();
    chk("err2", int'(cfg_err), 1);
    cfg_valid = 1'b0;
    tick();
    chk("err.off", int'(cfg_err), 0);
    chk_pos("err", 25, 0, 1);

    // key_valid is ignored while configuring.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("cfgkey.sv", int'(step_valid), 0);
    chk_pos("cfgkey", 25, 0, 1);

    // Write and done in one cycle.
    cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_pos = 5'd4; cfg_done = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_done = 1'b0;
    chk_pos("wrdone", 25, 4, 1);
    chk("wrdone.in_cfg", int'(in_cfg), 0);
    chk("wrdone.kr", int'(key_ready), 1);

    // Key wins over simultaneous cfg_start.
    key_valid = 1'b1; cfg_start = 1'b1;
    tick();
    key_valid = 1'b0; cfg_start = 1'b0;
    chk("race.sv", int'(step_valid), 1);
    chk("race.in_cfg", int'(in_cfg), 0);
`ifdef ROTOR_DOUBLE_STEP_EN
    chk_pos("race", 0, 5, 2);
`else
    chk_pos("race", 25, 4, 2);
`endif
    tick();
    chk("race.idle.kr", int'(key_ready), 1);
    chk("race.idle.in_cfg", int'(in_cfg), 0);
    enter_cfg();
    chk("start.in_cfg", int'(in_cfg), 1);
    chk("start.kr", int'(key_ready), 0);
`ifdef ROTOR_DOUBLE_STEP_EN
    chk_pos("start", 0, 5, 2);
`else
    chk_pos("start", 25, 4, 2);
`endif

    // Reset while in HOLD.
    finish_cfg();
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("hold.sv", int'(step_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_pos("rsthold", 0, 0, 0);
    chk("rsthold.sv", int'(step_valid), 0);
    chk("rsthold.in_cfg", int'(in_cfg), 1);
    chk("rsthold.kr", int'(key_ready), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
